serial_mag_cmp: RTL and testbench
=================================

# serial_mag_cmp

Sequential W-bit magnitude comparator built around the team's 4-bit cascadable comparator stage. It accepts an operand pair over a valid/ready handshake and walks the operands one nibble per clock, LSB nibble first. Each nibble's result is registered and fed back as the cascade input for the next more-significant nibble. It sits directly upstream of the 4-bit stage, sequencing its cascade inputs, and returns one GT/LT/EQ verdict per operand pair to the consumer.

## Interface
- W, 16: operand width; multiple of 4, ≥4. NIB = W/4 nibbles.
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept; high only in IDLE
- a  in  W  operand A
- b  in  W  operand B
- cin_gt, cin_lt, cin_eq  in  1 each  initial cascade flags, sampled with a/b; normally 0,0,1
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- gt, lt, eq  out  1 each  A>B, A<B, A==B (resolved through the cascade)
- busy  out  1  high in RUN and DONE

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid: latch a, b and cin_* into the cascade register; clear idx to 0; go to RUN.
- **RUN**
  - Each cycle, drive nibble idx (a[4*idx+3:4*idx], b[...]) and the cascade register into the 4-bit stage.
  - Register the stage outputs back into the cascade register.
  - If idx==NIB-1, go to DONE; otherwise idx++.
  - idx width is clog2(NIB), minimum 1. idx never wraps past NIB-1.
- **DONE**
  - out_valid=1. gt/lt/eq equal the cascade register.
  - On out_ready, go to IDLE.
- **Nibble stage semantics**
  - If the nibbles differ at the highest differing bit, that bit decides: GT=1 or LT=1, the other two flags 0.
  - If the nibbles are equal, the incoming cascade flags pass through unchanged.
  - Because nibbles run LSB-first, the final verdict is decided by the most-significant differing nibble.
- **Non-one-hot cin_*** is not corrected. If a==b, it appears verbatim on gt/lt/eq. Otherwise it is overwritten by the deciding nibble.
- **Operand stability:** a, b and cin_* are ignored outside the IDLE accept cycle. Internal copies are used for the whole run.
- **Reset mid-operation:** rst at any time aborts immediately and forces all reset values. No partial result is ever presented.
- **No early exit:** every transaction takes the full NIB RUN cycles, regardless of data.

## Timing
- **Reset values:**
  - state=IDLE, in_ready=1.
  - out_valid=0, busy=0.
  - gt=0, lt=0, eq=0.
  - idx=0.
  - Cascade register = 0,0,0.
- **Latency:** acceptance at edge E0. Nibbles are processed at edges E1..E_NIB. out_valid is high from edge E_NIB onward (NIB cycles after acceptance).
- **Handshake (out):** gt/lt/eq and out_valid hold stable while out_valid && !out_ready. Transfer happens at the edge where both are high, and out_valid drops at that edge.
- **Handshake (in):** in_ready drops at the edge after acceptance. in_valid with no in_ready is simply held off by the producer.
- **Throughput:** one pair per NIB+2 cycles when out_ready is held high (accept, NIB RUN cycles, DONE; in_ready returns one cycle later).
- **Combinational paths:** in_ready and out_valid decode from state only. There is no combinational path from in_valid or out_ready to any output.
- **gt/lt/eq** are combinationally the cascade register. They are only meaningful while out_valid=1.

## Structure
- Shared package cmp_pkg holds:
  - The state enum (IDLE, RUN, DONE).
  - A packed flag struct {gt, lt, eq}.
  - The constant CASCADE_INIT = {0,0,1}.
  - A function nib_count(W) returning W/4.
- One sub-module, nib_cmp4: the purely combinational 4-bit cascadable comparator, instantiated once. Its ports are cascade in gt/lt/eq, 4-bit a/b, and cascade out gt/lt/eq.
- Elaboration check: W%4==0 and W≥4, else fatal.

## Test plan
- W=16, a=0x1234, b=0x1234, cin=0,0,1, out_ready=1 → out_valid exactly 4 cycles after accept; gt=0, lt=0, eq=1.
- a=0x8000, b=0x7FFF → gt=1, lt=0, eq=0. Checks that the MSB nibble overrides the lower nibbles, which favour B.
- a=0x0001, b=0x0002 → lt=1. Then a=0xFFF0, b=0xFFF1 → lt=1 (lowest nibble decides, upper nibbles equal). Then a=0x1234, b=0x1234 with cin=1,0,0 → gt=1 (equal operands pass the cascade through).
- out_ready held 0 for 5 cycles in DONE → result and out_valid stay stable, in_ready stays 0, and a second in_valid is not accepted until one cycle after the transfer.
- Assert rst during RUN at idx=2 → all outputs immediately take reset values. A new pair (0x00FF vs 0x00FE) then completes normally with gt=1.
- Back-to-back pairs with out_ready=1 and in_valid=1 → accepts spaced exactly NIB+2=6 cycles apart, and results match the reference model for 1000 random pairs at W=16 and W=4.

Source files
------------

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared types and helpers for the serial magnitude comparator
package cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } flags_t;

    localparam flags_t CASCADE_INIT = '{gt: 1'b0, lt: 1'b0, eq: 1'b1};

    function automatic int nib_count(input int w);
        return w / 4;
    endfunction

endpackage

// File: rtl/nib_cmp4.sv
// rtl/nib_cmp4.sv - combinational 4-bit cascadable magnitude comparator stage
module nib_cmp4 (
    input  logic       cin_gt,
    input  logic       cin_lt,
    input  logic       cin_eq,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       cout_gt,
    output logic       cout_lt,
    output logic       cout_eq
);

    // A differing nibble decides outright; an equal nibble defers to the cascade.
    always_comb begin
        cout_gt = cin_gt;
        cout_lt = cin_lt;
        cout_eq = cin_eq;
        if (a > b) begin
            cout_gt = 1'b1;
            cout_lt = 1'b0;
            cout_eq = 1'b0;
        end else if (a < b) begin
            cout_gt = 1'b0;
            cout_lt = 1'b1;
            cout_eq = 1'b0;
        end
    end

endmodule

// File: rtl/serial_mag_cmp.sv
// rtl/serial_mag_cmp.sv - W-bit magnitude comparator walking one nibble per clock, LSB first
module serial_mag_cmp
    import cmp_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin_gt,
    input  logic         cin_lt,
    input  logic         cin_eq,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         gt,
    output logic         lt,
    output logic         eq,
    output logic         busy
);

    localparam int NIB   = nib_count(W);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIB - 1);

    if ((W % 4) != 0 || W < 4) begin : g_bad_width
        $fatal(1, "serial_mag_cmp: W must be a multiple of 4 and at least 4");
    end

    state_t           state;
    state_t           state_nx;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    flags_t           casc;
    flags_t           stage_out;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;

    always_comb begin
        nib_a = 4'h0;
        nib_b = 4'h0;
        for (int i = 0; i < NIB; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_a = a_q[4*i +: 4];
                nib_b = b_q[4*i +: 4];
            end
        end
    end

    nib_cmp4 u_nib (
        .cin_gt  (casc.gt),
        .cin_lt  (casc.lt),
        .cin_eq  (casc.eq),
        .a       (nib_a),
        .b       (nib_b),
        .cout_gt (stage_out.gt),
        .cout_lt (stage_out.lt),
        .cout_eq (stage_out.eq)
    );

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (in_valid)     state_nx = ST_RUN;
            ST_RUN:  if (idx == LAST)  state_nx = ST_DONE;
            ST_DONE: if (out_ready)    state_nx = ST_IDLE;
            default:                   state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            casc  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q  <= a;
                        b_q  <= b;
                        casc <= '{gt: cin_gt, lt: cin_lt, eq: cin_eq};
                        idx  <= '0;
                    end
                end
                ST_RUN: begin
                    casc <= stage_out;
                    // idx parks on the last nibble rather than wrapping.
                    if (idx != LAST) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign gt        = casc.gt;
    assign lt        = casc.lt;
    assign eq        = casc.eq;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// tb/tb_serial_mag_cmp.sv - directed and random self-checking bench for serial_mag_cmp
module tb_serial_mag_cmp;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [15:0] a, b;
    logic        cin_gt, cin_lt, cin_eq, gt, lt, eq;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [3:0]  a4, b4;
    logic        cin_gt4, cin_lt4, cin_eq4, gt4, lt4, eq4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_mag_cmp #(.W(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
        .cin_gt(cin_gt), .cin_lt(cin_lt), .cin_eq(cin_eq),
        .out_valid(out_valid), .out_ready(out_ready),
        .gt(gt), .lt(lt), .eq(eq), .busy(busy)
    );

    serial_mag_cmp #(.W(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4),
        .cin_gt(cin_gt4), .cin_lt(cin_lt4), .cin_eq(cin_eq4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .gt(gt4), .lt(lt4), .eq(eq4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_cmp(input logic [15:0] x, input logic [15:0] y,
                                           input logic [2:0] c);
        if (x > y) return 3'b100;
        if (x < y) return 3'b010;
        return c;
    endfunction

    task automatic pair16(input logic [15:0] x, input logic [15:0] y,
                          input logic [2:0] c, input logic [2:0] exp);
        int k;
        @(negedge clk);
        a = x; b = y; {cin_gt, cin_lt, cin_eq} = c;
        in_valid = 1'b1; out_ready = 1'b1;
        k = 0;
        while (!in_ready && k < 30) begin @(negedge clk); k++; end
        check("w16_ready_wait", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~x; b = ~y; {cin_gt, cin_lt, cin_eq} = ~c;
        check("w16_in_ready_drop", in_ready, 0);
        check("w16_busy", busy, 1);
        k = 0;
        while (!out_valid && k < 30) begin @(posedge clk); #1; k++; end
        check("w16_latency", k, 4);
        check("w16_result", {gt, lt, eq}, exp);
        @(posedge clk); #1;
        check("w16_out_valid_drop", out_valid, 0);
    endtask

    task automatic pair4(input logic [3:0] x, input logic [3:0] y,
                         input logic [2:0] c, input logic [2:0] exp);
        int k;
        @(negedge clk);
        a4 = x; b4 = y; {cin_gt4, cin_lt4, cin_eq4} = c;
        in_valid4 = 1'b1; out_ready4 = 1'b1;
        k = 0;
        while (!in_ready4 && k < 30) begin @(negedge clk); k++; end
        check("w4_ready_wait", in_ready4, 1);
        @(posedge clk); #1;
        in_valid4 = 1'b0; a4 = ~x; b4 = ~y;
        k = 0;
        while (!out_valid4 && k < 30) begin @(posedge clk); #1; k++; end
        check("w4_latency", k, 1);
        check("w4_result", {gt4, lt4, eq4}, exp);
        @(posedge clk); #1;
        check("w4_out_valid_drop", out_valid4, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, last, cyc;
        logic [15:0] x, y;
        logic [2:0]  c;
        logic [3:0]  x4, y4;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        {cin_gt, cin_lt, cin_eq} = 3'b001;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;
        {cin_gt4, cin_lt4, cin_eq4} = 3'b001;
        repeat (2) @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_flags", {gt, lt, eq}, 3'b000);
        check("reset_w4_flags", {gt4, lt4, eq4}, 3'b000);
        rst = 1'b0;

        pair16(16'h1234, 16'h1234, 3'b001, 3'b001);
        pair16(16'h8000, 16'h7FFF, 3'b001, 3'b100);
        pair16(16'h0001, 16'h0002, 3'b001, 3'b010);
        pair16(16'hFFF0, 16'hFFF1, 3'b001, 3'b010);
        pair16(16'h1234, 16'h1234, 3'b100, 3'b100);
        pair16(16'hABCD, 16'hABCD, 3'b011, 3'b011);
        pair16(16'h0F00, 16'h00FF, 3'b111, 3'b100);

        // Consumer stalls in DONE for 5 cycles while a second pair waits.
        @(negedge clk);
        a = 16'h00A0; b = 16'h0B00; {cin_gt, cin_lt, cin_eq} = 3'b001;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 30) begin @(posedge clk); #1; k++; end
        check("hold_latency", k, 4);
        a = 16'h0005; b = 16'h0003; {cin_gt, cin_lt, cin_eq} = 3'b001;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold_out_valid", out_valid, 1);
            check("hold_flags", {gt, lt, eq}, 3'b010);
            check("hold_in_ready", in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hold_transfer_valid", out_valid, 0);
        check("hold_transfer_ready", in_ready, 1);
        check("hold_transfer_busy", busy, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("hold_second_accept", busy, 1);
        k = 0;
        while (!out_valid && k < 30) begin @(posedge clk); #1; k++; end
        check("hold_second_latency", k, 4);
        check("hold_second_flags", {gt, lt, eq}, 3'b100);
        @(posedge clk); #1;

        // Reset asserted mid-run, two nibbles in.
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; {cin_gt, cin_lt, cin_eq} = 3'b001;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_flags", {gt, lt, eq}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        pair16(16'h00FF, 16'h00FE, 3'b001, 3'b100);

        // Back-to-back: in_valid and out_ready held high.
        @(negedge clk);
        a = 16'h4321; b = 16'h1234; {cin_gt, cin_lt, cin_eq} = 3'b001;
        in_valid = 1'b1; out_ready = 1'b1;
        last = -1;
        for (cyc = 0; cyc < 40; cyc++) begin
            if (in_ready) begin
                if (last >= 0) check("b2b_spacing", cyc - last, 6);
                last = cyc;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        k = 0;
        while (busy && k < 30) begin @(negedge clk); k++; end
        check("b2b_drain", busy, 0);

        pair4(4'h9, 4'h9, 3'b101, 3'b101);
        pair4(4'h8, 4'h7, 3'b001, 3'b100);
        pair4(4'h0, 4'hF, 3'b001, 3'b010);

        for (int i = 0; i < 1000; i++) begin
            x = 16'($urandom);
            y = (i % 8 == 0) ? x : 16'($urandom);
            c = 3'($urandom);
            pair16(x, y, c, ref_cmp(x, y, c));
        end
        for (int i = 0; i < 1000; i++) begin
            x4 = 4'($urandom);
            y4 = 4'($urandom);
            c  = 3'($urandom);
            pair4(x4, y4, c, ref_cmp({12'h0, x4}, {12'h0, y4}, c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
